// File: rtl/mcycle_seq_if.sv
// mcycle_seq_if -- launch/result bundle between the condition unit,
// the writeback path and the multi-cycle multiply/divide sequencer.
// master: drives Start/MCycleOp/operands and observes Busy/Done/results.
// slave:  the sequencer itself.
`timescale 1ns/1ps

interface mcycle_seq_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start,
        output MCycleOp,
        output Operand1,
        output Operand2,
        input  Result1,
        input  Result2,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Start,
        input  MCycleOp,
        input  Operand1,
        input  Operand2,
        output Result1,
        output Result2,
        output Busy,
        output Done
    );
endinterface

// File: rtl/mcycle_seq.sv
// mcycle_seq -- iterative multiply / divide sequencer.
// One shift-add (multiply) or restoring-divide step per cycle over a shared
// 2*WIDTH accumulator. Busy stalls the pipeline from the launching cycle
// until the cycle before Done; Done pulses for one cycle with results valid.
// Optional build macro: MCYCLE_SIGNED_EN enables two's-complement operation
// selected by MCycleOp[1]; without it every operation is unsigned.
`timescale 1ns/1ps

module mcycle_seq #(
    parameter int WIDTH = 32
) (
    input  logic        CLK,
    input  logic        Reset,
    mcycle_seq_if.slave bus
);

    localparam int              CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Sequencer state
    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    // Multiplicand (multiply) or divisor (divide), always as a magnitude
    logic [WIDTH-1:0]   opb_q;
    // Multiply: {partial product high, remaining multiplier bits}
    // Divide:   {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] acc_q;
    // Sign fix-ups applied to the unsigned core result on entry to DONE
    logic               neg_res_q;
    logic               neg_rem_q;
    // Registered outputs
    logic [WIDTH-1:0]   result1_q;
    logic [WIDTH-1:0]   result2_q;
    logic               done_q;

    // Launch-side decode
    logic               signed_op;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               launch;
    logic               div_by_zero;

    // Iteration datapath
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   result1_d;
    logic [WIDTH-1:0]   result2_d;

`ifndef MCYCLE_SIGNED_EN
    // MCycleOp[1] carries no meaning in the unsigned-only build.
    logic unused_sign_sel;
    assign unused_sign_sel = bus.MCycleOp[1];
`endif

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    // Operand conditioning: signs, magnitudes and launch qualification.
    always_comb begin
`ifdef MCYCLE_SIGNED_EN
        signed_op = bus.MCycleOp[1];
`else
        signed_op = 1'b0;
`endif
        sign1       = signed_op & bus.Operand1[WIDTH-1];
        sign2       = signed_op & bus.Operand2[WIDTH-1];
        mag1        = sign1 ? neg_w(bus.Operand1) : bus.Operand1;
        mag2        = sign2 ? neg_w(bus.Operand2) : bus.Operand2;
        // Start is only honoured when no operation is in flight.
        launch      = bus.Start && ((state_q == S_IDLE) || (state_q == S_DONE));
        div_by_zero = bus.MCycleOp[0] && (bus.Operand2 == {WIDTH{1'b0}});
    end

    // One multiply or divide step applied to the accumulator.
    always_comb begin
        addend  = acc_q[0] ? opb_q : {WIDTH{1'b0}};
        // Multiply: add the multiplicand into the upper half when the
        // current multiplier bit is set; the carry becomes the new MSB
        // as the whole accumulator shifts right.
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Divide: the shifted partial remainder needs WIDTH+1 bits, so
        // the bit that leaves the top of the accumulator joins the
        // trial subtraction.
        trial   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        if (!is_div_q) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // Final result formation from the last iteration, with sign fix-ups.
    always_comb begin
        prod_neg  = ~acc_d + ONE_2W;
        result1_d = acc_d[WIDTH-1:0];
        result2_d = acc_d[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            if (neg_res_q) begin
                result1_d = prod_neg[WIDTH-1:0];
                result2_d = prod_neg[2*WIDTH-1:WIDTH];
            end
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            if (neg_res_q) begin
                result1_d = neg_w(acc_d[WIDTH-1:0]);
            end
            if (neg_rem_q) begin
                result2_d = neg_w(acc_d[2*WIDTH-1:WIDTH]);
            end
        end
    end

    // Sequencer FSM: operand capture, iteration count and registered results.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result1_q <= '0;
            result2_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        is_div_q  <= bus.MCycleOp[0];
                        neg_res_q <= sign1 ^ sign2;
                        neg_rem_q <= sign1 & bus.MCycleOp[0];
                        count_q   <= '0;
                        if (div_by_zero) begin
                            // No iterations: report all-ones quotient and
                            // hand back the raw dividend.
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            opb_q     <= '0;
                            acc_q     <= '0;
                            result1_q <= {WIDTH{1'b1}};
                            result2_q <= bus.Operand1;
                        end else if (bus.MCycleOp[0]) begin
                            state_q <= S_COMPUTE;
                            opb_q   <= mag2;
                            acc_q   <= {{WIDTH{1'b0}}, mag1};
                        end else begin
                            state_q <= S_COMPUTE;
                            opb_q   <= mag1;
                            acc_q   <= {{WIDTH{1'b0}}, mag2};
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_COMPUTE: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        result1_q <= result1_d;
                        result2_q <= result2_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Busy covers the launching cycle as well as every compute cycle.
    assign bus.Busy    = launch || (state_q == S_COMPUTE);
    assign bus.Done    = done_q;
    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_seq.sv
// tb_mcycle_seq -- scoreboard bench for mcycle_seq (WIDTH=32).
// The driver pushes the expected results and completion cycle for every
// accepted launch; an independent negedge monitor pops on each Done pulse.
// Expected values come from plain integer arithmetic on the operands.
`timescale 1ns/1ps

module tb_mcycle_seq;

    localparam int W = 32;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   launch_cyc;
    int   pend_done;
    logic [31:0] last_r1;
    logic [31:0] last_r2;
    exp_t sb_q[$];
    exp_t mon_e;

    mcycle_seq_if #(.WIDTH(W)) bus ();

    mcycle_seq #(.WIDTH(W)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: plain integer arithmetic on the operands.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r1, output logic [31:0] r2);
        logic        sgn;
        longint      sa;
        longint      sb;
        longint      sres;
        longint      srem;
        logic [63:0] p;
        sgn = 1'b0;
`ifdef MCYCLE_SIGNED_EN
        sgn = op[1];
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (sgn) begin
                sres = sa * sb;
                p    = 64'(sres);
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 32'd0) begin
            r1 = 32'hFFFF_FFFF;
            r2 = a;
        end else if (sgn) begin
            sres = sa / sb;
            srem = sa % sb;
            p    = 64'(sres);
            r1   = p[31:0];
            p    = 64'(srem);
            r2   = p[31:0];
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endfunction

    // Issue one launch in the current cycle (called at posedge+1) and
    // record what the monitor must see; Start may stay high for 'hold'
    // further cycles with scrambled operands that must be ignored.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r1, input logic [31:0] r2, input int hold);
        exp_t e;
        int   lat;
        int   hcycles;
        lat          = (op[0] && (b == 32'd0)) ? 1 : W + 1;
        hcycles      = (lat == 1) ? 0 : hold;
        bus.Start    = 1'b1;
        bus.MCycleOp = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        e.r1  = r1;
        e.r2  = r2;
        e.cyc = cyc + lat;
        sb_q.push_back(e);
        launch_cyc = cyc;
        pend_done  = cyc + lat;
        $display("launch cycle=%0d op=%b a=%h b=%h exp_r1=%h exp_r2=%h hold=%0d",
                 cyc, op, a, b, r1, r2, hcycles);
        for (int h = 0; h < hcycles; h++) begin
            @(posedge clk);
            #1;
            bus.Operand1 = $urandom;
            bus.Operand2 = $urandom;
            bus.MCycleOp = 2'($urandom);
        end
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic launch_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int hold);
        logic [31:0] r1;
        logic [31:0] r2;
        model(op, a, b, r1, r2);
        launch(op, a, b, r1, r2, hold);
    endtask

    // Return at posedge+1 of the cycle in which Done is high (bounded).
    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (bus.Done === 1'b1) return;
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
    endtask

    function automatic logic [31:0] rand_operand(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return allow_zero ? 32'd0 : 32'd1;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3, 4:    return 32'($urandom_range(1, 20));
            5:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: scoreboard pops on Done, hold/busy checks otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_r1 = 32'd0;
            last_r2 = 32'd0;
        end else begin
            if (bus.Done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result1", bus.Result1, mon_e.r1);
                    chk("result2", bus.Result2, mon_e.r2);
                    chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                    $display("done cycle=%0d r1=%h r2=%h", cyc, bus.Result1, bus.Result2);
                end
                last_r1 = bus.Result1;
                last_r2 = bus.Result2;
            end else begin
                chk("result1_hold", bus.Result1, last_r1);
                chk("result2_hold", bus.Result2, last_r2);
            end
            chk("busy", {31'b0, bus.Busy},
                {31'b0, (bus.Start === 1'b1) ||
                        (launch_cyc >= 0 && cyc > launch_cyc && cyc < pend_done)});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        clk          = 1'b0;
        rst          = 1'b1;
        cyc          = 0;
        checks       = 0;
        failures     = 0;
        launch_cyc   = -1;
        pend_done    = -1;
        last_r1      = 32'd0;
        last_r2      = 32'd0;
        bus.Start    = 1'b0;
        bus.MCycleOp = 2'b00;
        bus.Operand1 = 32'd0;
        bus.Operand2 = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.Busy}, 32'd0);
        chk("reset_done", {31'b0, bus.Done}, 32'd0);
        chk("reset_result1", bus.Result1, 32'd0);
        chk("reset_result2", bus.Result2, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 7 x 6
        launch(2'b00, 32'd7, 32'd6, 32'h0000_002A, 32'd0, 0);
        wait_done();
        @(posedge clk);
        #1;

        // all-ones squared, Start held through the whole computation
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, W);
        wait_done();
        @(posedge clk);
        #1;

        // 100 / 7, then back-to-back 9 / 3 launched in the Done cycle
        launch(2'b01, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        wait_done();
        launch(2'b01, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        wait_done();
        @(posedge clk);
        #1;

        // divide by zero
        launch(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
        wait_done();
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset mid-computation
        launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst        = 1'b1;
        sb_q.delete();
        launch_cyc = -1;
        pend_done  = -1;
        #1;
        chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
        chk("abort_done", {31'b0, bus.Done}, 32'd0);
        chk("abort_result1", bus.Result1, 32'd0);
        chk("abort_result2", bus.Result2, 32'd0);
        $display("reset asserted cycle=%0d", cyc);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        launch(2'b00, 32'd3, 32'd4, 32'd12, 32'd0, 0);
        wait_done();
        @(posedge clk);
        #1;

`ifdef MCYCLE_SIGNED_EN
        launch(2'b10, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 0);
        wait_done();
        @(posedge clk);
        #1;
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        wait_done();
        @(posedge clk);
        #1;
`endif

        // randomized operations, gaps, holds and back-to-back launches
        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = rand_operand(1'b1);
            b  = rand_operand(1'b1);
            launch_model(op, a, b, int'($urandom_range(0, 8)));
            wait_done();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcycle_seq.md
Name: mcycle_seq

Overview:
Iterative multi-cycle multiply/divide sequencer that owns the shared shift-add/restoring-divide datapath. It is launched by the condition-qualified MStart strobe from the condition unit and holds Busy so the pipeline stalls until the result is ready. It returns a double-width product, or a quotient plus remainder, to the register-file writeback path.

Parameters:
WIDTH, 32, operand and result width in bits (>=4).

Ports:
CLK  input  1  clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  launch request (driven by MStart); sampled only in IDLE or DONE.
MCycleOp  input  2  bit0: 0=multiply, 1=divide; bit1: 1=signed (used only with MCYCLE_SIGNED_EN).
Operand1  input  WIDTH  multiplicand / dividend; captured on the accepting edge.
Operand2  input  WIDTH  multiplier / divisor; captured on the accepting edge.
Result1  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
Result2  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
Busy  output  1  stall request to the pipeline.
Done  output  1  one-cycle pulse; Result1/Result2 valid.

Behaviour:
- Reset (async): state=IDLE, count=0; Result1, Result2, Busy and Done all 0. All operand/working registers cleared.
- States:
  - IDLE: Start=1 -> capture operands and op. Divide with Operand2==0 goes to DONE; otherwise goes to COMPUTE with count=0.
  - COMPUTE: one iteration per cycle; count increments; after WIDTH iterations (count==WIDTH-1) -> DONE.
  - DONE: Done=1 for exactly this cycle. Start=1 behaves as in IDLE (back-to-back launch); otherwise -> IDLE.
- Busy is combinational: (state==IDLE & Start) | (state==DONE & Start) | state==COMPUTE. The launching instruction stalls in the same cycle as Start. Busy is 0 during the Done cycle unless a new Start is accepted.
- Start during COMPUTE is ignored; operands are not re-sampled.
- Latency: Start in cycle 0 -> Done in cycle WIDTH+1. Divide-by-zero: Done in cycle 1.
- Multiply (shift-add): 2*WIDTH accumulator; each iteration adds the multiplicand (shifted) when the current multiplier LSB is 1, then shifts. Product is exact modulo 2^(2*WIDTH).
- Divide (restoring): 2*WIDTH partial-remainder register. Each iteration shifts left 1, trial-subtracts the divisor from the upper half, and keeps the result if non-negative with quotient bit 1, else restores with quotient bit 0.
- Divide-by-zero: Result1 = all ones, Result2 = Operand1 (raw captured dividend).
- Result1/Result2 update only on the edge entering DONE. They hold until the next entry to DONE; they do not change during COMPUTE.
- Reset mid-COMPUTE aborts immediately: no Done pulse, results 0, and the next Start runs normally.

Optional Feature:
Macro MCYCLE_SIGNED_EN.
- Defined:
  - MCycleOp[1]=1 selects two's-complement signed operation. Operands are converted to magnitudes at capture and the unsigned core runs unchanged.
  - On entry to DONE, the product is negated when the operand signs differ. The quotient is negated when signs differ (truncation toward zero); the remainder takes the dividend's sign.
  - Signed divide-by-zero gives Result1 = all ones, Result2 = Operand1.
  - Latency is unchanged.
- Undefined: MCycleOp[1] is ignored; all operations are unsigned.

Test Plan:
- WIDTH=32, multiply 7 x 6, Start pulse in cycle 0 -> Busy=1 cycles 0..32, Done=1 only in cycle 33, Result1=0x0000002A, Result2=0.
- Multiply 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE; Start held high through COMPUTE causes no relaunch.
- Divide 100 / 7 -> Result1=14, Result2=2 at cycle 33. Then Start in the Done cycle with 9 / 3 -> second Done 33 cycles later, Result1=3, Result2=0.
- Divide 5 / 0 -> Done in cycle 1, Result1=0xFFFFFFFF, Result2=5; Busy=1 only in cycle 0.
- Reset asserted mid-COMPUTE (cycle 10) -> Busy, Done, Result1 and Result2 are 0 immediately; no Done pulse; next multiply 3 x 4 gives 12.
- With MCYCLE_SIGNED_EN, MCycleOp=2'b10, (-6) x 7 -> Result1=0xFFFFFFD6, Result2=0xFFFFFFFF. MCycleOp=2'b11, (-7) / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
